// File: rtl/muldiv.sv
// RV32M multiply/divide unit in EX; shift-add multiply and restoring divide, one bit per cycle.
// Latency: out_valid DATAW+1 cycles after accept; divide-by-zero/overflow (and MUL* with fast multiplier) in 1 cycle.
// Backpressure: in_ready only in IDLE; result and out_valid are held in DONE until out_ready; flush aborts anything.
// Optional build macro MULDIV_FAST_MUL_EN: MUL* use a single-cycle multiplier and complete in 1 cycle.
module muldiv #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [DATAW-1:0] a,
  input  logic [DATAW-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] result
);

  localparam int W  = DATAW;
  localparam int CW = $clog2(DATAW) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     r_state;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;      // mul: {partial hi, remaining multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]   r_opnd;     // mul: multiplicand magnitude; div: divisor magnitude
  logic [2:0]     r_op;
  logic           r_neg;      // final result must be negated
  logic [W-1:0]   r_result;
  logic           r_out_valid;

  logic           w_accept;
  logic           w_is_div;
  logic           w_sgn_a;
  logic           w_sgn_b;
  logic           w_neg_a;
  logic           w_neg_b;
  logic [W-1:0]   w_ma;
  logic [W-1:0]   w_mb;
  logic           w_b_zero;
  logic           w_ovf;
  logic           w_special;
  logic [W-1:0]   w_special_res;
  logic           w_neg_new;
  logic           w_direct;
  logic [W-1:0]   w_direct_res;
  logic [W:0]     w_mul_sum;
  logic [2*W-1:0] w_mul_next;
  logic [W:0]     w_rem_sh;
  logic [W:0]     w_diff;
  logic [2*W-1:0] w_div_next;
  logic [2*W-1:0] w_step;
  logic           w_last;
  logic [W-1:0]   w_final_res;

  // Apply the sign correction to an unsigned magnitude result and pick the architectural word.
  function automatic logic [W-1:0] f_finish(input logic [2:0] fop, input logic fneg,
                                             input logic [2*W-1:0] facc);
    logic [2*W-1:0] p;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic [W-1:0]   res;
    p = fneg ? -facc : facc;
    q = facc[W-1:0];
    r = facc[2*W-1:W];
    if (!fop[2]) begin
      res = (fop[1:0] == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    end else if (fop[1]) begin
      res = fneg ? -r : r;
    end else begin
      res = fneg ? -q : q;
    end
    return res;
  endfunction

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;

  // Operand decode at accept time: signedness, magnitudes, special cases.
  always_comb begin
    w_accept = in_valid & in_ready & ~flush;
    w_is_div = op[2];
    // Unsigned a only for MULHU/DIVU/REMU; b additionally unsigned for MULHSU.
    w_sgn_a  = ~(op[0] & (op[1] | op[2]));
    w_sgn_b  = w_sgn_a & (op != 3'b010);
    w_neg_a  = w_sgn_a & a[W-1];
    w_neg_b  = w_sgn_b & b[W-1];
    w_ma     = w_neg_a ? -a : a;
    w_mb     = w_neg_b ? -b : b;
    w_b_zero = (b == '0);
    w_ovf    = w_is_div & ~op[0] & (a == {1'b1, {(W-1){1'b0}}}) & (b == '1);
    w_special = w_is_div & (w_b_zero | w_ovf);
    if (!op[1]) begin
      w_special_res = w_b_zero ? '1 : a;
    end else begin
      w_special_res = w_b_zero ? a : '0;
    end
    // Remainder follows the dividend; quotient and products follow sign(a)^sign(b).
    w_neg_new = (w_is_div & op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*W-1:0] w_fast_prod;
  logic [W-1:0]   w_fast_res;

  // Single-cycle multiply path; divides still iterate unless special.
  always_comb begin
    w_fast_prod  = {{W{1'b0}}, w_ma} * {{W{1'b0}}, w_mb};
    w_fast_res   = f_finish(op, w_neg_new, w_fast_prod);
    w_direct     = w_special | ~w_is_div;
    w_direct_res = w_is_div ? w_special_res : w_fast_res;
  end
`else
  // Only divide special cases bypass the iteration.
  always_comb begin
    w_direct     = w_special;
    w_direct_res = w_special_res;
  end
`endif

  // One iteration of shift-add multiply or restoring divide on the latched state.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    w_mul_next  = {w_mul_sum, r_acc[W-1:1]};
    w_rem_sh    = {r_acc[2*W-1:W], r_acc[W-1]};
    w_diff      = w_rem_sh - {1'b0, r_opnd};
    w_div_next  = w_diff[W] ? {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0}
                            : {w_diff[W-1:0],   r_acc[W-2:0], 1'b1};
    w_step      = r_op[2] ? w_div_next : w_mul_next;
    w_last      = (r_state == S_BUSY) && (r_cnt == CW'(DATAW - 1));
    w_final_res = f_finish(r_op, r_neg, w_step);
  end

  // Control FSM and registered result/out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_direct) begin
              r_result    <= w_direct_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (w_last) begin
            r_result    <= w_final_res;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // Datapath: latch operands on accept, then advance one bit per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opnd <= '0;
      r_op   <= '0;
      r_neg  <= 1'b0;
    end else if ((r_state == S_IDLE) && w_accept) begin
      r_cnt  <= '0;
      r_op   <= op;
      r_neg  <= w_neg_new;
      r_opnd <= w_is_div ? w_mb : w_ma;
      r_acc  <= w_is_div ? {{W{1'b0}}, w_ma} : {{W{1'b0}}, w_mb};
    end else if (r_state == S_BUSY) begin
      r_cnt  <= r_cnt + CW'(1);
      r_acc  <= w_step;
    end
  end

endmodule

// File: tb/tb_muldiv.sv
// Directed bench for muldiv: scoreboard of expected result/latency per accepted op.
// Latency is counted in cycles after the accept edge (accept cycle = 0).
// Outputs are sampled 1 ns after the rising edge; inputs change on the falling edge.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  muldiv #(.DATAW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference results from native wide arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    int          ix, iy;
    logic        ovf;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    ix = $signed(x);
    iy = $signed(y);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    r = '0;
    case (o)
      3'd0: begin p = sx * sy; r = p[31:0];  end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: r = (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : ix / iy);
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: r = (y == 0) ? x : (ovf ? 32'd0 : ix % iy);
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2] && ((y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    if (!o[2] && FAST) return 1;
    return 33;
  endfunction

  // Accept one op, wait for its result, compare, then consume it.
  task automatic run_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] expv, input string tag);
    int lat;
    @(negedge clk);
    op = o; a = xa; b = xb; in_valid = 1'b1;
    check({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
    exp_q.push_back(expv);
    lat_q.push_back(exp_lat(o, xa, xb));
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, lat_q.pop_front());
    check({tag, "/result"}, result, exp_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/out_valid_after"}, {31'd0, out_valid}, 32'd0);
    check({tag, "/in_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb, held;
    int          seen;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = '0; b = '0;

    // 1. reset values, then MUL
    repeat (3) @(posedge clk);
    #1;
    check("rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("rst/in_ready", {31'd0, in_ready}, 32'd1);
    check("rst/result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst/in_ready", {31'd0, in_ready}, 32'd1);
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");

    // 2. high-half multiplies
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU");

    // 3. divides
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "DIV -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "REM -7%2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "DIVU 100/7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, "REMU 100%7");

    // 4. special cases
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, "DIV 5/0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, "REMU 5%0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "REM ovf");

    // random ops against the wide-arithmetic model
    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      run_op(ro, ra, rb, model(ro, ra, rb), "random");
    end

    // 5. result held under backpressure; new requests ignored
    @(negedge clk);
    op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    op = 3'd0; a = 32'd3; b = 32'd3;
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(posedge clk); #1;
      seen++;
    end
    held = 32'd14;
    for (int i = 0; i < 10; i++) begin
      check("hold/result", result, held);
      check("hold/in_ready", {31'd0, in_ready}, 32'd0);
      check("hold/out_valid", {31'd0, out_valid}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release/in_ready", {31'd0, in_ready}, 32'd1);
    check("release/out_valid", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("release/no_stray_op", seen, 32'd0);

    // 6a. flush in cycle 10 of a DIV
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy/out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_busy/in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("flush_busy/no_result", seen, 32'd0);

    // 6b. flush with in_valid in IDLE drops the op
    @(negedge clk);
    op = 3'd4; a = 32'd5; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle/in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("flush_idle/no_result", seen, 32'd0);

    // 6c. async reset mid-BUSY (result currently holds 2 from a REMU earlier? no: last consumed was 14)
    @(negedge clk);
    op = 3'd5; a = 32'd77; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("async_rst/out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst/in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst/result", result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_op(3'd5, 32'd77, 32'd5, 32'd15, "DIVU after reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
